// File: rtl/lzc_share_arbiter_if.sv
// Request/response bundle between the requesters, the result consumer and the shared LZC arbiter.
// Requester i owns req_data[32*i+31:32*i]; the master side drives requests and resp_ready.
interface lzc_share_arbiter_if #(
    parameter int NREQ = 3,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               resp_valid;
    logic               resp_ready;
    logic [ID_W-1:0]    resp_id;
    logic [4:0]         resp_index;
    logic [5:0]         resp_lzc;
    logic               resp_zero;

    modport master (
        output req_valid,
        output req_data,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_id,
        input  resp_index,
        input  resp_lzc,
        input  resp_zero
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_id,
        output resp_index,
        output resp_lzc,
        output resp_zero
    );
endinterface

// File: rtl/lzc_share_arbiter.sv
// Round-robin sharing of one 32-bit priority encoder between NREQ requesters,
// with a capture stage and a registered result stage (MSB index, LZC, zero flag, requester ID).

module PriorityEncoder32 (
    input  logic [31:0] data_i,
    output logic [4:0]  index_o
);
    // Later (higher) set bits overwrite earlier ones, leaving the MSB position; zero input gives 0.
    always_comb begin
        index_o = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (data_i[i]) begin
                index_o = 5'(i);
            end
        end
    end
endmodule

module lzc_share_arbiter #(
    parameter int NREQ = 3,
    parameter int ID_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    lzc_share_arbiter_if.slave   arbBus
);
    logic               s1Valid_q, s1Valid_d;
    logic [31:0]        s1Data_q,  s1Data_d;
    logic [ID_W-1:0]    s1Id_q,    s1Id_d;
    logic               s2Valid_q, s2Valid_d;
    logic [ID_W-1:0]    s2Id_q,    s2Id_d;
    logic [4:0]         s2Index_q, s2Index_d;
    logic [5:0]         s2Lzc_q,   s2Lzc_d;
    logic               s2Zero_q,  s2Zero_d;
    logic [ID_W-1:0]    rrPtr_q,   rrPtr_d;

    logic               s2Load;
    logic               s1Free;
    logic               grantFound;
    logic [ID_W-1:0]    grantIdx;
    logic [31:0]        grantData;
    logic               canAccept;
    logic [NREQ-1:0]    reqReady;
    logic [4:0]         encIndex;
    logic               encZero;

    function automatic logic [ID_W-1:0] wrapIdx(input logic [ID_W-1:0] base, input int offset);
        int unsigned sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return ID_W'(sum);
    endfunction

    PriorityEncoder32 u_encoder (
        .data_i  (s1Data_q),
        .index_o (encIndex)
    );

    assign encZero   = (s1Data_q == 32'd0);
    assign s2Load    = s1Valid_q & (~s2Valid_q | arbBus.resp_ready);
    assign s1Free    = ~s1Valid_q | s2Load;
    assign canAccept = grantFound & s1Free & ~reset;

    // Scan from rrPtr upward with wraparound; first valid requester wins.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grantFound && arbBus.req_valid[wrapIdx(rrPtr_q, k)]) begin
                grantFound = 1'b1;
                grantIdx   = wrapIdx(rrPtr_q, k);
            end
        end
    end

    always_comb begin
        grantData = 32'd0;
        reqReady  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantIdx == ID_W'(i)) begin
                grantData   = arbBus.req_data[32*i +: 32];
                reqReady[i] = canAccept;
            end
        end
    end

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Data_d  = s1Data_q;
        s1Id_d    = s1Id_q;
        rrPtr_d   = rrPtr_q;
        s2Valid_d = s2Valid_q;
        s2Id_d    = s2Id_q;
        s2Index_d = s2Index_q;
        s2Lzc_d   = s2Lzc_q;
        s2Zero_d  = s2Zero_q;

        // Result fields hold after a handshake; only the valid bit drops.
        if (s2Load) begin
            s2Valid_d = 1'b1;
            s2Id_d    = s1Id_q;
            s2Index_d = encIndex;
            s2Zero_d  = encZero;
            s2Lzc_d   = encZero ? 6'd32 : (6'd31 - {1'b0, encIndex});
        end else if (s2Valid_q && arbBus.resp_ready) begin
            s2Valid_d = 1'b0;
        end

        if (canAccept) begin
            s1Valid_d = 1'b1;
            s1Data_d  = grantData;
            s1Id_d    = grantIdx;
            rrPtr_d   = wrapIdx(grantIdx, 1);
        end else if (s2Load) begin
            s1Valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1Valid_q <= 1'b0;
            s1Data_q  <= 32'd0;
            s1Id_q    <= '0;
            rrPtr_q   <= '0;
            s2Valid_q <= 1'b0;
            s2Id_q    <= '0;
            s2Index_q <= 5'd0;
            s2Lzc_q   <= 6'd0;
            s2Zero_q  <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Data_q  <= s1Data_d;
            s1Id_q    <= s1Id_d;
            rrPtr_q   <= rrPtr_d;
            s2Valid_q <= s2Valid_d;
            s2Id_q    <= s2Id_d;
            s2Index_q <= s2Index_d;
            s2Lzc_q   <= s2Lzc_d;
            s2Zero_q  <= s2Zero_d;
        end
    end

    assign arbBus.req_ready  = reqReady;
    assign arbBus.resp_valid = s2Valid_q;
    assign arbBus.resp_id    = s2Id_q;
    assign arbBus.resp_index = s2Index_q;
    assign arbBus.resp_lzc   = s2Lzc_q;
    assign arbBus.resp_zero  = s2Zero_q;
endmodule
